// File: rtl/jtag_shift_engine.sv
`default_nettype none
//==============================================================================
// Module      : jtag_shift_engine
// Description : Parametrised JTAG vector shifter. Issues up to C_VEC_WIDTH TCK
//               cycles per command, driving TMS/TDI LSB-first and capturing
//               TDO into a vector of the same width. Runtime TCK divider,
//               start/busy/done handshake and abort.
// Revision    : 1.0 - initial release
//==============================================================================
module jtag_shift_engine #(
   parameter int C_VEC_WIDTH = 32,
   parameter int C_DIV_WIDTH = 16,
   parameter int C_LEN_WIDTH = $clog2(C_VEC_WIDTH + 1)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [C_LEN_WIDTH-1:0] length_i,
   input  logic [C_DIV_WIDTH-1:0] clk_div_i,
   input  logic [C_VEC_WIDTH-1:0] tms_vec_i,
   input  logic [C_VEC_WIDTH-1:0] tdi_vec_i,
   output logic [C_VEC_WIDTH-1:0] tdo_vec_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   tck_o,
   output logic                   tms_o,
   output logic                   tdi_o,
   input  logic                   tdo_i
);

   // Bit index only needs to address the vector; the length field needs one
   // extra code point to represent a full-width command.
   localparam int                     C_IDX_WIDTH = (C_VEC_WIDTH > 1) ? $clog2(C_VEC_WIDTH) : 1;
   localparam logic [C_LEN_WIDTH-1:0] C_MAX_LEN   = C_LEN_WIDTH'(C_VEC_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TCK_LO = 2'd1,
      S_TCK_HI = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                 state_q;
   logic [C_LEN_WIDTH-1:0] len_q;
   logic [C_DIV_WIDTH-1:0] div_q;
   logic [C_DIV_WIDTH-1:0] cnt_q;
   logic [C_IDX_WIDTH-1:0] idx_q;
   logic [C_VEC_WIDTH-1:0] tms_vec_q;
   logic [C_VEC_WIDTH-1:0] tdi_vec_q;
   logic [C_VEC_WIDTH-1:0] tdo_sr_q;
   logic [C_VEC_WIDTH-1:0] tdo_vec_q;
   logic                   tck_q;
   logic                   tms_q;
   logic                   tdi_q;
   logic                   busy_q;
   logic                   done_q;

   logic [C_LEN_WIDTH-1:0] len_d;
   logic [C_DIV_WIDTH-1:0] div_d;
   logic [C_IDX_WIDTH-1:0] idx_d;
   logic [C_VEC_WIDTH-1:0] tdo_sr_d;
   logic                   phase_end;
   logic                   last_bit;

   // Command operand conditioning, capture merge and phase/bit terminal counts.
   always_comb begin
      len_d           = (length_i > C_MAX_LEN) ? C_MAX_LEN : length_i;
      div_d           = (clk_div_i == '0) ? C_DIV_WIDTH'(1) : clk_div_i;
      idx_d           = idx_q + 1'b1;
      tdo_sr_d        = tdo_sr_q;
      tdo_sr_d[idx_q] = tdo_i;
      phase_end       = (cnt_q == (div_q - 1'b1));
      last_bit        = (C_LEN_WIDTH'(idx_q) == (len_q - 1'b1));
   end

   // Shift FSM: all pin and handshake outputs are registered here.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         div_q     <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         tms_vec_q <= '0;
         tdi_vec_q <= '0;
         tdo_sr_q  <= '0;
         tdo_vec_q <= '0;
         tck_q     <= 1'b0;
         tms_q     <= 1'b1;
         tdi_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i && !abort_i) begin
                  len_q     <= len_d;
                  div_q     <= div_d;
                  tms_vec_q <= tms_vec_i;
                  tdi_vec_q <= tdi_vec_i;
                  idx_q     <= '0;
                  cnt_q     <= '0;
                  tdo_sr_q  <= '0;
                  if (len_d == '0) begin
                     // Empty command completes immediately with no TCK activity.
                     state_q   <= S_DONE;
                     done_q    <= 1'b1;
                     tdo_vec_q <= '0;
                  end else begin
                     state_q <= S_TCK_LO;
                     busy_q  <= 1'b1;
                     tms_q   <= tms_vec_i[0];
                     tdi_q   <= tdi_vec_i[0];
                  end
               end
            end

            S_TCK_LO: begin
               if (abort_i) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  tck_q   <= 1'b0;
               end else if (phase_end) begin
                  cnt_q   <= '0;
                  tck_q   <= 1'b1;
                  state_q <= S_TCK_HI;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_TCK_HI: begin
               if (abort_i) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  tck_q   <= 1'b0;
               end else if (phase_end) begin
                  // TCK falls here; the target only changes TDO after this edge.
                  cnt_q    <= '0;
                  tck_q    <= 1'b0;
                  tdo_sr_q <= tdo_sr_d;
                  if (last_bit) begin
                     state_q   <= S_DONE;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     tdo_vec_q <= tdo_sr_d;
                  end else begin
                     idx_q   <= idx_d;
                     tms_q   <= tms_vec_q[idx_d];
                     tdi_q   <= tdi_vec_q[idx_d];
                     state_q <= S_TCK_LO;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign tdo_vec_o = tdo_vec_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign tck_o     = tck_q;
   assign tms_o     = tms_q;
   assign tdi_o     = tdi_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_shift_engine.sv
`default_nettype none
//==============================================================================
// Module      : tb_jtag_shift_engine
// Description : Self-checking bench for jtag_shift_engine (64-bit vectors).
//               A behavioural JTAG target drives TDO; expected waveforms and
//               captured vectors are derived from command parameters.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_jtag_shift_engine;

   localparam int VW = 64;
   localparam int DW = 16;
   localparam int LW = $clog2(VW + 1);

   localparam int M_RAND = 0;   // target returns a pre-drawn random bit per TCK
   localparam int M_LOOP = 1;   // TDO = TDI combinationally
   localparam int M_BYP  = 2;   // one-bit bypass register, TDI delayed one TCK

   logic          clk_i     = 1'b0;
   logic          reset_i   = 1'b1;
   logic          start_i   = 1'b0;
   logic          abort_i   = 1'b0;
   logic [LW-1:0] length_i  = '0;
   logic [DW-1:0] clk_div_i = '0;
   logic [VW-1:0] tms_vec_i = '0;
   logic [VW-1:0] tdi_vec_i = '0;
   logic [VW-1:0] tdo_vec_o;
   logic          busy_o, done_o, tck_o, tms_o, tdi_o, tdo_i;

   int n_vec = 0;
   int n_err = 0;

   int            mode     = M_RAND;
   logic [VW-1:0] rnd_bits = '0;
   logic          byp_q    = 1'b0;
   logic          tdi_rise = 1'b0;
   logic          tck_prev = 1'b0;
   logic [6:0]    fall_cnt = '0;

   always #5 clk_i = ~clk_i;

   jtag_shift_engine #(
      .C_VEC_WIDTH(VW),
      .C_DIV_WIDTH(DW)
   ) dut (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .start_i  (start_i),
      .abort_i  (abort_i),
      .length_i (length_i),
      .clk_div_i(clk_div_i),
      .tms_vec_i(tms_vec_i),
      .tdi_vec_i(tdi_vec_i),
      .tdo_vec_o(tdo_vec_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .tck_o    (tck_o),
      .tms_o    (tms_o),
      .tdi_o    (tdi_o),
      .tdo_i    (tdo_i)
   );

   // Behavioural JTAG target: reacts to observed TCK edges, resets itself while idle.
   assign tdo_i = (mode == M_LOOP) ? tdi_o :
                  (mode == M_BYP)  ? byp_q : rnd_bits[fall_cnt[5:0]];

   always @(negedge clk_i) begin
      tck_prev <= tck_o;
      if (!busy_o && !tck_o) begin
         fall_cnt <= '0;
         byp_q    <= 1'b0;
      end else begin
         if (!tck_prev && tck_o) tdi_rise <= tdi_o;
         if (tck_prev && !tck_o) begin
            fall_cnt <= fall_cnt + 7'd1;
            byp_q    <= tdi_rise;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mask_of(input int l);
      if (l >= 64) return '1;
      return (64'd1 << l) - 64'd1;
   endfunction

   // Issue one command and check the whole TCK/TMS/TDI/busy/done waveform.
   task automatic run_cmd(input int len, input int div, input logic [63:0] tms,
                          input logic [63:0] tdi, input int md, input bit hold);
      int            l, d, t, bad_tck, bad_pin, bad_busy, done_at, idx;
      logic [63:0]   exp;
      l = (len > VW) ? VW : len;
      d = (div == 0) ? 1 : div;
      t = 2 * l * d;
      @(negedge clk_i);
      mode     = md;
      rnd_bits = {$urandom, $urandom};
      case (md)
         M_LOOP:  exp = tdi & mask_of(l);
         M_BYP:   exp = (tdi << 1) & mask_of(l);
         default: exp = rnd_bits & mask_of(l);
      endcase
      length_i  = LW'(len);
      clk_div_i = DW'(div);
      tms_vec_i = tms;
      tdi_vec_i = tdi;
      start_i   = 1'b1;
      bad_tck = 0; bad_pin = 0; bad_busy = 0; done_at = -1;
      for (int c = 1; c <= t + 3; c++) begin
         @(negedge clk_i);
         if (c == 1 && !hold) start_i = 1'b0;
         if (done_o) begin
            if (done_at < 0) done_at = c;
            else bad_busy++;
         end
         if (c <= t) begin
            idx = (c - 1) / (2 * d);
            if (tck_o !== ((((c - 1) / d) % 2) == 1)) bad_tck++;
            if (tms_o !== tms[idx] || tdi_o !== tdi[idx]) bad_pin++;
            if (busy_o !== 1'b1) bad_busy++;
         end else begin
            if (tck_o !== 1'b0) bad_tck++;
            if (busy_o !== 1'b0) bad_busy++;
            if (l > 0 && (tms_o !== tms[l-1] || tdi_o !== tdi[l-1])) bad_pin++;
         end
         if (c == t + 1 && hold) start_i = 1'b0;
         // Inputs must be ignored once the command is latched.
         length_i  = LW'($urandom);
         clk_div_i = DW'($urandom);
         tms_vec_i = {$urandom, $urandom};
         tdi_vec_i = {$urandom, $urandom};
      end
      chk("tck_wave", 64'(bad_tck), 64'd0);
      chk("pins", 64'(bad_pin), 64'd0);
      chk("busy", 64'(bad_busy), 64'd0);
      chk("done_lat", 64'(done_at), 64'(t + 1));
      chk("tdo_vec", tdo_vec_o, exp);
   endtask

   initial begin
      logic [63:0] prior;
      logic        h_tms, h_tdi, prev;
      int          rises, bad;

      // Reset state
      repeat (3) @(negedge clk_i);
      chk("rst_tck", 64'(tck_o), 64'd0);
      chk("rst_tms", 64'(tms_o), 64'd1);
      chk("rst_tdi", 64'(tdi_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_tdo", tdo_vec_o, 64'd0);
      reset_i = 1'b0;

      // Directed cases
      run_cmd(8, 1, 64'h1F, 64'hA5, M_BYP, 1'b0);
      chk("bypass_tdo", tdo_vec_o, 64'h4A);
      run_cmd(32, 4, {$urandom, $urandom}, 64'hDEADBEEF, M_LOOP, 1'b0);
      chk("loop_tdo", tdo_vec_o, 64'h00000000DEADBEEF);
      run_cmd(100, 1, {$urandom, $urandom}, {$urandom, $urandom}, M_RAND, 1'b0);
      run_cmd(0, 3, {$urandom, $urandom}, {$urandom, $urandom}, M_RAND, 1'b0);
      run_cmd(5, 0, {$urandom, $urandom}, {$urandom, $urandom}, M_LOOP, 1'b0);
      run_cmd(64, 2, {$urandom, $urandom}, {$urandom, $urandom}, M_BYP, 1'b1);
      run_cmd(1, 1, 64'h1, 64'h0, M_RAND, 1'b1);

      // Abort after the third TCK rising edge
      run_cmd(40, 1, {$urandom, $urandom}, {$urandom, $urandom}, M_RAND, 1'b0);
      prior = tdo_vec_o;
      @(negedge clk_i);
      mode      = M_RAND;
      length_i  = LW'(16);
      clk_div_i = DW'(2);
      tms_vec_i = {$urandom, $urandom};
      tdi_vec_i = {$urandom, $urandom};
      start_i   = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      prev    = tck_o;
      rises   = 0;
      for (int c = 0; c < 200 && rises < 3; c++) begin
         @(negedge clk_i);
         if (tck_o && !prev) rises++;
         prev = tck_o;
      end
      chk("abort_rises", 64'(rises), 64'd3);
      h_tms   = tms_o;
      h_tdi   = tdi_o;
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      chk("abort_tck", 64'(tck_o), 64'd0);
      chk("abort_busy", 64'(busy_o), 64'd0);
      chk("abort_done", 64'(done_o), 64'd0);
      chk("abort_tdo", tdo_vec_o, prior);
      bad = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk_i);
         if (tck_o || busy_o || done_o || tms_o !== h_tms || tdi_o !== h_tdi) bad++;
      end
      chk("abort_quiet", 64'(bad), 64'd0);

      // start together with abort in idle is rejected
      @(negedge clk_i);
      length_i  = LW'(8);
      clk_div_i = DW'(1);
      start_i   = 1'b1;
      abort_i   = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      abort_i = 1'b0;
      bad     = 0;
      for (int c = 0; c < 20; c++) begin
         if (tck_o || busy_o || done_o) bad++;
         @(negedge clk_i);
      end
      chk("start_abort", 64'(bad), 64'd0);

      // Reset in the middle of a TCK high phase
      @(negedge clk_i);
      mode      = M_RAND;
      length_i  = LW'(16);
      clk_div_i = DW'(3);
      tms_vec_i = '0;
      tdi_vec_i = '1;
      start_i   = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      for (int c = 0; c < 50 && !tck_o; c++) @(negedge clk_i);
      chk("pre_rst_tck", 64'(tck_o), 64'd1);
      reset_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b0;
      chk("mid_rst_tck", 64'(tck_o), 64'd0);
      chk("mid_rst_tms", 64'(tms_o), 64'd1);
      chk("mid_rst_tdi", 64'(tdi_o), 64'd0);
      chk("mid_rst_tdo", tdo_vec_o, 64'd0);
      chk("mid_rst_busy", 64'(busy_o), 64'd0);
      run_cmd(12, 2, {$urandom, $urandom}, {$urandom, $urandom}, M_BYP, 1'b0);

      // Randomised commands
      for (int n = 0; n < 12; n++) begin
         run_cmd(int'($urandom_range(0, 72)), int'($urandom_range(0, 3)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jtag_shift_engine.md
Name: jtag_shift_engine

Overview:
- Parametrised successor to the fixed 32-bit JTAG shift processor behind the AXI4-Lite XVC register interface.
- Shifts up to C_VEC_WIDTH TMS/TDI bits LSB-first per command and captures TDO into a vector of the same width.
- Adds a runtime TCK divider, an explicit start/busy/done handshake, abort, and defined zero/over-length handling.
- Sits between the AXI register front-end and the TCK/TMS/TDI/TDO pins.

Parameters:
- C_VEC_WIDTH, 32, maximum bits per command and width of the TMS/TDI/TDO vectors (1..1024).
- C_DIV_WIDTH, 16, width of the runtime TCK half-period divider.
- C_LEN_WIDTH, $clog2(C_VEC_WIDTH+1), width of the length field (derived; do not override).

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  command request; sampled only while idle.
- abort_i  in  1  cancels an active command.
- length_i  in  C_LEN_WIDTH  number of TCK cycles to issue.
- clk_div_i  in  C_DIV_WIDTH  TCK half-period in clk_i cycles (0 is treated as 1).
- tms_vec_i  in  C_VEC_WIDTH  TMS bits; bit0 is shifted first.
- tdi_vec_i  in  C_VEC_WIDTH  TDI bits; bit0 is shifted first.
- tdo_vec_o  out  C_VEC_WIDTH  captured TDO; bit i is the TDO value for TCK cycle i.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle pulse on normal completion.
- tck_o  out  1  JTAG clock.
- tms_o  out  1  JTAG TMS.
- tdi_o  out  1  JTAG TDI.
- tdo_i  in  1  JTAG TDO, already synchronised to clk_i.

Behaviour:
- Reset values: tck_o=0, tms_o=1, tdi_o=0, busy_o=0, done_o=0, tdo_vec_o=0, FSM=IDLE, counters cleared. Reset takes priority at any point, including mid-command.
- FSM states: IDLE, TCK_LO, TCK_HI, DONE.
- Command acceptance:
  - In IDLE with start_i=1 and abort_i=0 at edge k, the block latches length (clamped to C_VEC_WIDTH), div (max(clk_div_i,1)), tms_vec_i and tdi_vec_i, and clears its bit index and TDO shift register.
  - Input changes while busy are ignored.
- length==0: no TCK activity. done_o=1 at k+1, busy_o stays 0, tdo_vec_o is cleared to 0.
- length>0:
  - From k+1: busy_o=1, tms_o/tdi_o = bit0, state TCK_LO.
  - TCK_LO: tck_o=0 for div cycles, then go to TCK_HI.
  - TCK_HI: tck_o=1 for div cycles.
  - TDO capture: on the edge that ends TCK_HI (tck_o 1->0), tdo_i is written into bit[index]. The target updates TDO on the TCK falling edge, so TDO is still stable at this sample.
  - Same edge, if index<len-1: index increments, tms_o/tdi_o update to bit[index+1], return to TCK_LO.
  - Same edge, if index==len-1: go to DONE with tck_o=0.
- DONE (one cycle): done_o=1, busy_o=0, tdo_vec_o updated, bits >= len read 0; then return to IDLE.
- Latency: done_o is asserted at k + 2*len*div + 1. TCK duty is exactly 50%, period 2*div clk_i cycles.
- Pin holding: tms_o/tdi_o hold the last shifted bit while idle; tck_o idles low.
- Abort:
  - abort_i=1 while busy: at the next edge tck_o=0 and state=IDLE. busy_o drops on that edge.
  - No done_o pulse; tdo_vec_o keeps its previous value; tms_o/tdi_o hold their current value.
  - abort_i together with start_i in IDLE: the command is rejected.
- start_i while busy: ignored, not queued.
- The index counter never wraps: it saturates at len-1, which is always ≤ C_VEC_WIDTH-1.

Test Plan:
- len=8, div=1, tms=0x1F, tdi=0xA5, TDO model returns its own TDI delayed one TCK (bypass) -> 8 TCK pulses at period 2, done_o at k+17, tdo_vec_o=0x4A (bit0 = reset value 0).
- len=32, div=4, C_VEC_WIDTH=64, tdi=0xDEADBEEF, TDO model loops tdi back combinationally -> tdo_vec_o=0x00000000DEADBEEF, tck high/low 4 cycles each, done_o at k+257.
- len=100 with C_VEC_WIDTH=64 -> clamped to 64 TCK pulses; len=0 -> done_o at k+1, no TCK edge, tdo_vec_o=0.
- Abort asserted after the 3rd TCK rising edge of a len=16 command -> tck_o=0 the next cycle, busy_o=0, no done_o, tdo_vec_o unchanged from the prior command.
- start_i held high through a busy command, and start+abort in idle -> exactly one command executes; the start+abort pair produces no activity.
- reset_i asserted mid-TCK_HI -> next cycle tck_o=0, tms_o=1, tdi_o=0, tdo_vec_o=0, busy_o=0; a new command then runs normally.
